// File: rtl/pixel_write_arbiter.sv
// Frame-buffer write arbiter: FIFO-buffered line-drawing pixels merged with a
// full-screen clear engine that has priority, one registered write per cycle.
module pixel_write_arbiter #(
  parameter int unsigned       ADDR_W      = 19,
  parameter int unsigned       DATA_W      = 6,
  parameter int unsigned       DEPTH       = 16,
  parameter int unsigned       FB_SIZE     = 307200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_clear,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              fb_ready,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CLR_W = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(FB_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              overflow_q, overflow_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0] fb_data_q, fb_data_d;
  logic              clear_done_q, clear_done_d;
  logic              push, pop;
  logic              full_c, empty_c;

  assign full_c  = (cnt_q == CNT_FULL);
  assign empty_c = (cnt_q == '0);

  // State register and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      clr_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      overflow_q   <= overflow_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      clear_done_q <= clear_done_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_addr, in_data};
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    pop          = 1'b0;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    clear_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (fb_ready && !empty_c) begin
          pop                    = 1'b1;
          fb_we_d                = 1'b1;
          {fb_addr_d, fb_data_d} = mem_q[rd_ptr_q];
        end
      end
      CLEAR: begin
        if (fb_ready) begin
          fb_we_d   = 1'b1;
          fb_addr_d = ADDR_W'(clr_cnt_q);
          fb_data_d = CLEAR_COLOR;
          if (clr_cnt_q == CLR_LAST) begin
            state_d      = IDLE;
            clear_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    push       = in_we && (!full_c || pop);
    overflow_d = overflow_q | (in_we && full_c && !pop);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d      = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fifo_full  = full_c;
  assign fifo_empty = empty_c;
  assign overflow   = overflow_q;
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clear_done_q;

endmodule
